// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD = 4'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_t;
endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: input/output valid-ready handshake bundle of the converter.
interface bin2bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int DIGITS = 5
);
  logic in_valid;
  logic in_ready;
  logic [BIN_W-1:0] binary_in;
  logic out_valid;
  logic out_ready;
  logic [DIGIT_W*DIGITS-1:0] bcd_out;
  logic overflow;
  logic busy;
  modport master (
    output in_valid, binary_in, out_ready,
    input in_ready, out_valid, bcd_out, overflow, busy
  );
  modport slave (
    input in_valid, binary_in, out_ready,
    output in_ready, out_valid, bcd_out, overflow, busy
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble cell, adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);
  always_comb q = (d >= ADJ_THRESH) ? d + ADJ_ADD : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, one shift/adjust step per clock,
// valid/ready on both sides with back-to-back accept from DONE.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int DIGITS = 5
) (
  input logic clk,
  input logic rst_n,
  bin2bcd_seq_if.slave io
);
  localparam int BW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic ovf_q, ovf_d;
  logic accept;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.d(bcd_q[i*DIGIT_W +: DIGIT_W]), .q(adj[i*DIGIT_W +: DIGIT_W]));
  end
  assign io.in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE && io.out_ready);
  assign io.out_valid = state_q == ST_DONE;
  assign io.busy = state_q == ST_CONV;
  assign io.bcd_out = bcd_q;
  assign io.overflow = ovf_q;
  assign accept = io.in_valid && io.in_ready;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    if (accept) begin
      state_d = ST_CONV;
      cnt_d = CW'(BIN_W);
      bin_d = io.binary_in;
      bcd_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == ST_CONV) begin
      // a carry out of the top digit means the value no longer fits in DIGITS
      bcd_d = {adj[BW-2:0], bin_q[BIN_W-1]};
      bin_d = bin_q << 1;
      ovf_d = ovf_q | adj[BW-1];
      cnt_d = cnt_q - CW'(1);
      state_d = (cnt_q == CW'(1)) ? ST_DONE : ST_CONV;
    end else if (state_q == ST_DONE && io.out_ready) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
